fruit_motion: RTL and testbench
===============================

# fruit_motion

Single-fruit trajectory engine. Accepts one launch descriptor per flight from the launch-parameter lookup (start column, speeds, direction) over a valid/ready handshake. Advances the fruit position once per video frame under constant gravity. Reports when the fruit leaves the playfield. Sits between the random launch path and the sprite renderer and slice-detection logic.

## Interface
- SCREEN_W, 1024, playfield width in pixels; x valid range 0..SCREEN_W-1
- SCREEN_H, 768, playfield height in pixels; y valid range 0..SCREEN_H-1, 0 = top
- GRAVITY, 1, vertical speed decrement applied each frame
- MAX_FALL, 15, magnitude limit on downward speed
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous assert, active-low
- frame_tick_in  input  1  one-cycle pulse per frame; the motion update strobe
- launch_valid_in  input  1  launch descriptor present
- launch_ready_out  output  1  high exactly when state = IDLE (combinational from state)
- x_start_in  input  11  launch column
- x_vel_in  input  3  horizontal speed, pixels/frame
- y_vel_in  input  5  initial upward speed, pixels/frame
- x_direction_neg_in  input  1  1 = move toward decreasing x
- slice_in  input  1  fruit was cut this cycle
- x_pos_out  output  11  current column
- y_pos_out  output  11  current row
- active_out  output  1  fruit in flight (FLY or HIT)
- sliced_out  output  1  current or last flight was sliced
- done_out  output  1  one-cycle pulse when the fruit exits

## Operation
- States:
  - IDLE: waiting for a launch.
  - FLY: whole fruit in flight.
  - HIT: sliced fruit, still falling.
- Internal state:
  - vy: signed 6-bit vertical speed, positive = up.
  - vx: unsigned 3-bit horizontal speed.
  - dir: direction bit.
- IDLE → FLY on launch_valid_in & launch_ready_out. On acceptance:
  - x_pos = x_start_in, y_pos = SCREEN_H-1
  - vy = y_vel_in, vx = x_vel_in, dir = x_direction_neg_in
  - sliced_out cleared to 0
- Each frame_tick_in in FLY or HIT, compute in signed 13-bit:
  - x_n = x_pos ± vx; minus when dir = 1.
  - y_n = y_pos − vy.
  - vy_n = max(vy − GRAVITY, −MAX_FALL).
- Exit occurs when x_n < 0, x_n ≥ SCREEN_W, or y_n ≥ SCREEN_H. On exit:
  - Positions are not updated and keep their last in-range values.
  - Next state is IDLE.
  - done_out pulses.
- When there is no exit, positions and vy take the new values. y_n < 0 cannot occur for y_vel_in ≤ 31; no clamp is required.
- slice_in in FLY: next state HIT, sliced_out = 1, vx = 0, vy = min(vy, 0).
- HIT exits only through the bottom or side conditions; x is frozen because vx = 0.
- slice_in in IDLE or HIT is ignored.
- launch_valid_in outside IDLE is ignored; no descriptor is buffered.

## Timing
- Reset values:
  - state = IDLE
  - x_pos_out = 0, y_pos_out = 0
  - vy = 0, vx = 0
  - active_out = 0, sliced_out = 0, done_out = 0
  - launch_ready_out = 1
- Launch accepted at edge N: positions valid and active_out = 1 from cycle N+1. The first update happens on the first frame_tick_in after N.
- A frame_tick_in in the same cycle as launch acceptance is ignored for motion.
- Position update: registered, 1 cycle after frame_tick_in.
- Exit:
  - done_out is high for exactly the cycle after the exiting tick.
  - In that same cycle: active_out = 0 and launch_ready_out = 1.
  - A launch may be accepted in that cycle.
- slice_in and frame_tick_in in the same cycle (FLY):
  - The motion update uses the pre-slice vx/vy.
  - The slice modifications are then applied: vx = 0, vy = min(vy_n, 0).
  - If that same tick exits, the exit wins: state = IDLE, sliced_out = 1, done_out pulses.
- Asynchronous reset mid-flight: all outputs return to their reset values immediately. No done_out is emitted.

## Test plan
- Nominal arc:
  - Stimulus: x_start = 400, x_vel = 2, dir = 0, y_vel = 10.
  - Tick 1 → (402, 757); tick 2 → (404, 748).
  - Tick 10 → y = 712, vy = 0; tick 11 → y = 712.
  - Tick 21 → (442, 767).
  - Tick 22 → done_out pulse; positions hold (442, 767).
- Left-edge exit:
  - Stimulus: x_start = 2, dir = 1, x_vel = 4, y_vel = 12.
  - Tick 1 → done_out pulse, x stays 2, y stays 767, back in IDLE.
- Slice while rising:
  - Stimulus: the nominal launch, then slice_in after tick 3 (y = 740, vy = 7).
  - sliced_out = 1, state HIT.
  - Next tick: x unchanged, y = 740, vy = −1.
  - The fruit then exits through the bottom.
- Simultaneous slice and tick at the exiting tick:
  - done_out pulses, sliced_out = 1, state IDLE.
- Handshake:
  - Stimulus: launch_valid_in held high throughout a flight.
  - launch_ready_out = 0 while active; no reload occurs.
  - The next launch is accepted in the done_out cycle; active_out is 1 again the following cycle.
- Reset mid-flight:
  - Stimulus: rst_in low asynchronously at tick 5.
  - Outputs go to their reset values without a clock edge; no done_out.
  - After release, a new launch works normally.

Source files
------------

// File: rtl/fruit_motion.sv
// Single-fruit trajectory engine: accepts a launch descriptor, moves the fruit
// once per frame under constant gravity and flags when it leaves the playfield.
module fruit_motion #(
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_tick_in,
  input  logic        launch_valid_in,
  output logic        launch_ready_out,
  input  logic [10:0] x_start_in,
  input  logic [2:0]  x_vel_in,
  input  logic [4:0]  y_vel_in,
  input  logic        x_direction_neg_in,
  input  logic        slice_in,
  output logic [10:0] x_pos_out,
  output logic [10:0] y_pos_out,
  output logic        active_out,
  output logic        sliced_out,
  output logic        done_out
);

  // state | meaning
  // IDLE  | waiting for a launch descriptor
  // FLY   | whole fruit in flight
  // HIT   | sliced fruit, still falling
  typedef enum logic [1:0] {IDLE, FLY, HIT} state_t;

  localparam logic signed [12:0] GRAV13 = 13'(GRAVITY);
  localparam logic signed [12:0] FALL13 = 13'(-MAX_FALL);
  localparam logic signed [12:0] W13    = 13'(SCREEN_W);
  localparam logic signed [12:0] H13    = 13'(SCREEN_H);

  state_t             state;
  logic [10:0]        x_pos;
  logic [10:0]        y_pos;
  logic signed [5:0]  vy;
  logic [2:0]         vx;
  logic               dir;
  logic               sliced;
  logic               done;

  logic signed [12:0] x_ext;
  logic signed [12:0] vx_ext;
  logic signed [12:0] y_ext;
  logic signed [12:0] vy_ext;
  logic signed [12:0] x_n;
  logic signed [12:0] y_n;
  logic signed [12:0] vy_dec;
  logic signed [5:0]  vy_n;
  logic               exit_hit;

  always_comb begin
    x_ext    = signed'({2'b00, x_pos});
    vx_ext   = signed'({10'b0, vx});
    y_ext    = signed'({2'b00, y_pos});
    vy_ext   = {{7{vy[5]}}, vy};
    x_n      = dir ? (x_ext - vx_ext) : (x_ext + vx_ext);
    y_n      = y_ext - vy_ext;
    vy_dec   = vy_ext - GRAV13;
    vy_n     = (vy_dec < FALL13) ? signed'(FALL13[5:0]) : signed'(vy_dec[5:0]);
    exit_hit = (x_n < 13'sd0) || (x_n >= W13) || (y_n >= H13);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      x_pos  <= '0;
      y_pos  <= '0;
      vy     <= '0;
      vx     <= '0;
      dir    <= 1'b0;
      sliced <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_valid_in) begin
            state  <= FLY;
            x_pos  <= x_start_in;
            y_pos  <= 11'(SCREEN_H - 1);
            vy     <= signed'({1'b0, y_vel_in});
            vx     <= x_vel_in;
            dir    <= x_direction_neg_in;
            sliced <= 1'b0;
          end
        end
        FLY, HIT: begin
          if (frame_tick_in) begin
            if (exit_hit) begin
              // exit wins over a coincident slice, but the slice is still recorded
              state <= IDLE;
              done  <= 1'b1;
              if (state == FLY && slice_in) sliced <= 1'b1;
            end else begin
              x_pos <= x_n[10:0];
              y_pos <= y_n[10:0];
              if (state == FLY && slice_in) begin
                state  <= HIT;
                sliced <= 1'b1;
                vx     <= '0;
                vy     <= vy_n[5] ? vy_n : 6'sd0;
              end else begin
                vy <= vy_n;
              end
            end
          end else if (state == FLY && slice_in) begin
            state  <= HIT;
            sliced <= 1'b1;
            vx     <= '0;
            vy     <= vy[5] ? vy : 6'sd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign launch_ready_out = (state == IDLE);
  assign active_out       = (state != IDLE);
  assign x_pos_out        = x_pos;
  assign y_pos_out        = y_pos;
  assign sliced_out       = sliced;
  assign done_out         = done;

endmodule

// File: tb/tb_fruit_motion.sv
// Directed bench for fruit_motion: hand-computed arcs, edge exits, slicing,
// handshake and asynchronous reset.
module tb_fruit_motion;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        frame_tick_in;
  logic        launch_valid_in;
  logic        launch_ready_out;
  logic [10:0] x_start_in;
  logic [2:0]  x_vel_in;
  logic [4:0]  y_vel_in;
  logic        x_direction_neg_in;
  logic        slice_in;
  logic [10:0] x_pos_out;
  logic [10:0] y_pos_out;
  logic        active_out;
  logic        sliced_out;
  logic        done_out;

  int checks = 0;
  int errors = 0;

  fruit_motion dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .frame_tick_in      (frame_tick_in),
    .launch_valid_in    (launch_valid_in),
    .launch_ready_out   (launch_ready_out),
    .x_start_in         (x_start_in),
    .x_vel_in           (x_vel_in),
    .y_vel_in           (y_vel_in),
    .x_direction_neg_in (x_direction_neg_in),
    .slice_in           (slice_in),
    .x_pos_out          (x_pos_out),
    .y_pos_out          (y_pos_out),
    .active_out         (active_out),
    .sliced_out         (sliced_out),
    .done_out           (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic launch(input int xs, input int xv, input int yv, input int d);
    x_start_in         = 11'(xs);
    x_vel_in           = 3'(xv);
    y_vel_in           = 5'(yv);
    x_direction_neg_in = d[0];
    launch_valid_in    = 1'b1;
    step();
    launch_valid_in    = 1'b0;
  endtask

  task automatic tick();
    frame_tick_in = 1'b1;
    step();
    frame_tick_in = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"}, x_pos_out, 0);
    chk({tag, "_y"}, y_pos_out, 0);
    chk({tag, "_active"}, active_out, 0);
    chk({tag, "_sliced"}, sliced_out, 0);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_ready"}, launch_ready_out, 1);
  endtask

  initial begin
    int n;
    bit seen;
    rst_in = 1'b0;
    frame_tick_in = 1'b0;
    launch_valid_in = 1'b0;
    x_start_in = '0;
    x_vel_in = '0;
    y_vel_in = '0;
    x_direction_neg_in = 1'b0;
    slice_in = 1'b0;
    #1;
    chk_reset_outputs("rst");
    step();
    step();
    rst_in = 1'b1;
    step();

    // nominal arc
    launch(400, 2, 10, 0);
    chk("nom_launch_x", x_pos_out, 400);
    chk("nom_launch_y", y_pos_out, 767);
    chk("nom_launch_active", active_out, 1);
    chk("nom_launch_ready", launch_ready_out, 0);
    for (int k = 1; k <= 22; k++) begin
      tick();
      case (k)
        1: begin
          chk("nom_t1_x", x_pos_out, 402);
          chk("nom_t1_y", y_pos_out, 757);
          step();
          chk("nom_hold_y", y_pos_out, 757);
        end
        2: begin
          chk("nom_t2_x", x_pos_out, 404);
          chk("nom_t2_y", y_pos_out, 748);
        end
        10: chk("nom_t10_y", y_pos_out, 712);
        11: chk("nom_t11_y", y_pos_out, 712);
        21: begin
          chk("nom_t21_x", x_pos_out, 442);
          chk("nom_t21_y", y_pos_out, 767);
          chk("nom_t21_done", done_out, 0);
        end
        22: begin
          chk("nom_exit_done", done_out, 1);
          chk("nom_exit_x", x_pos_out, 442);
          chk("nom_exit_y", y_pos_out, 767);
          chk("nom_exit_active", active_out, 0);
          chk("nom_exit_ready", launch_ready_out, 1);
        end
        default: ;
      endcase
    end
    step();
    chk("nom_done_pulse", done_out, 0);

    // left-edge exit; tick coincident with acceptance is ignored
    frame_tick_in = 1'b1;
    launch(2, 4, 12, 1);
    frame_tick_in = 1'b0;
    chk("left_accept_x", x_pos_out, 2);
    chk("left_accept_y", y_pos_out, 767);
    tick();
    chk("left_done", done_out, 1);
    chk("left_x", x_pos_out, 2);
    chk("left_y", y_pos_out, 767);
    chk("left_ready", launch_ready_out, 1);

    // slice while rising
    step();
    launch(400, 2, 10, 0);
    tick(); tick(); tick();
    chk("slc_t3_y", y_pos_out, 740);
    slice_in = 1'b1;
    step();
    slice_in = 1'b0;
    chk("slc_sliced", sliced_out, 1);
    chk("slc_active", active_out, 1);
    tick();
    chk("slc_t4_x", x_pos_out, 406);
    chk("slc_t4_y", y_pos_out, 740);
    tick();
    chk("slc_t5_y", y_pos_out, 741);
    n = 2;
    seen = 0;
    while (!seen && n < 60) begin
      tick();
      n++;
      if (done_out) seen = 1;
    end
    chk("slc_exit_seen", seen, 1);
    chk("slc_exit_ticks", n, 8);
    chk("slc_exit_x", x_pos_out, 406);
    chk("slc_exit_y", y_pos_out, 761);

    // slice coinciding with the exiting tick
    step();
    launch(400, 2, 10, 0);
    chk("sim_sliced_clr", sliced_out, 0);
    for (int k = 1; k <= 21; k++) tick();
    slice_in = 1'b1;
    tick();
    slice_in = 1'b0;
    chk("sim_done", done_out, 1);
    chk("sim_sliced", sliced_out, 1);
    chk("sim_ready", launch_ready_out, 1);
    chk("sim_active", active_out, 0);

    // handshake: valid held across a whole flight
    step();
    x_start_in = 11'd100;
    x_vel_in = 3'd1;
    y_vel_in = 5'd5;
    x_direction_neg_in = 1'b0;
    launch_valid_in = 1'b1;
    step();
    chk("hs_accept_x", x_pos_out, 100);
    x_start_in = 11'd900;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("hs_ready_low", launch_ready_out, 0);
    end
    chk("hs_no_reload_x", x_pos_out, 111);
    chk("hs_t11_y", y_pos_out, 767);
    tick();
    chk("hs_done", done_out, 1);
    chk("hs_done_ready", launch_ready_out, 1);
    step();
    launch_valid_in = 1'b0;
    chk("hs_reaccept_active", active_out, 1);
    chk("hs_reaccept_x", x_pos_out, 900);
    chk("hs_reaccept_done", done_out, 0);

    // asynchronous reset mid-flight at tick 5
    for (int k = 1; k <= 4; k++) tick();
    chk("rmf_t4_x", x_pos_out, 904);
    frame_tick_in = 1'b1;
    #2;
    rst_in = 1'b0;
    #1;
    chk_reset_outputs("rmf");
    frame_tick_in = 1'b0;
    step();
    chk("rmf_no_done", done_out, 0);
    step();
    rst_in = 1'b1;
    step();
    chk("rmf_idle_done", done_out, 0);
    launch(400, 2, 10, 0);
    tick();
    chk("rmf_relaunch_x", x_pos_out, 402);
    chk("rmf_relaunch_y", y_pos_out, 757);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
